// File: rtl/exec_unit_p.sv
// Execute stage with a parametrised ALU, flag register, branch resolution and data movement.
// Shifts and rotates step one bit per cycle so wide datapaths avoid a barrel shifter.
`timescale 1ns/1ps
module exec_unit_p #(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       aluop,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [WIDTH-1:0] immdata,
  input  logic [WIDTH-1:0] memorydata,
  input  logic [WIDTH-1:0] dipsdata,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_output,
  output logic             en_write,
  output logic             en_writedm,
  output logic [WIDTH-1:0] DatainMemory,
  output logic [WIDTH:0]   datainseg,
  output logic             jump,
  output logic [3:0]       flags
);

  localparam logic [5:0] OP_ADD = 6'd1,  OP_AND = 6'd2,  OP_SUB = 6'd3,  OP_OR = 6'd4;
  localparam logic [5:0] OP_XOR = 6'd5,  OP_MOV = 6'd6,  OP_NOT = 6'd7,  OP_SAR = 6'd8;
  localparam logic [5:0] OP_SLR = 6'd9,  OP_SAL = 6'd10, OP_SLL = 6'd11, OP_ROL = 6'd12;
  localparam logic [5:0] OP_ROR = 6'd13, OP_INC = 6'd14, OP_DEC = 6'd15;
  localparam logic [5:0] OP_SHOWRSEG = 6'd17, OP_CMP = 6'd18, OP_JE = 6'd19, OP_JB = 6'd20;
  localparam logic [5:0] OP_JA = 6'd21, OP_JL = 6'd22, OP_JG = 6'd23, OP_JMP = 6'd24;
  localparam logic [5:0] OP_LI = 6'd25, OP_LM = 6'd26, OP_STOREDM = 6'd27, OP_LDIP = 6'd28;
  localparam logic [5:0] OP_SHOWDM = 6'd29, OP_SHOWDMSEG = 6'd30;

  localparam logic [WIDTH-1:0] W_VAL   = WIDTH'(WIDTH);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [SHW:0]     W_CNT   = (SHW+1)'(WIDTH);
  localparam logic [SHW:0]     CNT_ONE = (SHW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   acc_reg, acc_next;
  logic [SHW:0]       cnt_reg, cnt_next;
  logic [5:0]         op_reg, op_next;
  logic               msb_reg, msb_next;
  logic [WIDTH-1:0]   data_reg, data_next;
  logic [WIDTH-1:0]   dm_reg, dm_next;
  logic [WIDTH-1:0]   seg_reg, seg_next;
  logic [3:0]         flags_reg, flags_next;
  logic               en_write_reg, en_write_next;
  logic               en_writedm_reg, en_writedm_next;
  logic               jump_reg, jump_next;
  logic               seg_show_reg, seg_show_next;

  logic               is_shift, is_rot;
  logic [SHW:0]       shamt;
  logic [WIDTH-1:0]   add_b, sub_b, logic_res;
  logic [WIDTH:0]     add_res, sub_res;
  logic               add_of, sub_of;
  logic [WIDTH-1:0]   step_acc;
  logic               step_bit;
  logic               zf, cf, of, sf;

  assign {zf, cf, of, sf} = flags_reg;

  assign is_shift = (aluop >= OP_SAR) && (aluop <= OP_ROR);
  assign is_rot   = (aluop == OP_ROL) || (aluop == OP_ROR);
  // Shifts saturate at WIDTH (everything shifted out); rotates wrap.
  assign shamt = is_rot ? (SHW+1)'(op2 % W_VAL)
                        : ((op2 > W_VAL) ? W_CNT : (SHW+1)'(op2));

  assign add_b   = (aluop == OP_INC) ? ONE : op2;
  assign sub_b   = (aluop == OP_DEC) ? ONE : op2;
  assign add_res = {1'b0, op1} + {1'b0, add_b};
  assign sub_res = {1'b0, op1} - {1'b0, sub_b};
  assign add_of  = (op1[WIDTH-1] == add_b[WIDTH-1]) && (add_res[WIDTH-1] != op1[WIDTH-1]);
  assign sub_of  = (op1[WIDTH-1] != sub_b[WIDTH-1]) && (sub_res[WIDTH-1] != op1[WIDTH-1]);
  assign logic_res = (aluop == OP_AND) ? (op1 & op2) :
                     (aluop == OP_OR)  ? (op1 | op2) : (op1 ^ op2);

  // One-bit step of the captured shift/rotate; step_bit is the bit leaving the word.
  always_comb begin
    step_acc = {acc_reg[WIDTH-2:0], 1'b0};
    step_bit = acc_reg[WIDTH-1];
    case (op_reg)
      OP_SAR: begin step_acc = {acc_reg[WIDTH-1], acc_reg[WIDTH-1:1]}; step_bit = acc_reg[0]; end
      OP_SLR: begin step_acc = {1'b0, acc_reg[WIDTH-1:1]};             step_bit = acc_reg[0]; end
      OP_ROL: begin step_acc = {acc_reg[WIDTH-2:0], acc_reg[WIDTH-1]};  step_bit = acc_reg[WIDTH-1]; end
      OP_ROR: begin step_acc = {acc_reg[0], acc_reg[WIDTH-1:1]};        step_bit = acc_reg[0]; end
      default: ;
    endcase
  end

  always_comb begin
    state_next      = state_reg;
    acc_next        = acc_reg;
    cnt_next        = cnt_reg;
    op_next         = op_reg;
    msb_next        = msb_reg;
    data_next       = data_reg;
    dm_next         = dm_reg;
    seg_next        = seg_reg;
    flags_next      = flags_reg;
    en_write_next   = 1'b0;
    en_writedm_next = 1'b0;
    jump_next       = 1'b0;
    seg_show_next   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (in_valid) begin
          if (is_shift && (shamt != '0)) begin
            acc_next   = op1;
            cnt_next   = shamt;
            op_next    = aluop;
            msb_next   = op1[WIDTH-1];
            state_next = S_SHIFT;
          end else begin
            state_next = S_DONE;
            case (aluop)
              OP_ADD, OP_INC: begin
                data_next     = add_res[WIDTH-1:0];
                en_write_next = 1'b1;
                flags_next    = {add_res[WIDTH-1:0] == '0, add_res[WIDTH], add_of, add_res[WIDTH-1]};
              end
              OP_SUB, OP_DEC, OP_CMP: begin
                if (aluop != OP_CMP) begin
                  data_next     = sub_res[WIDTH-1:0];
                  en_write_next = 1'b1;
                end
                flags_next = {sub_res[WIDTH-1:0] == '0, sub_res[WIDTH], sub_of, sub_res[WIDTH-1]};
              end
              OP_AND, OP_OR, OP_XOR: begin
                data_next     = logic_res;
                en_write_next = 1'b1;
                flags_next    = {logic_res == '0, 2'b00, logic_res[WIDTH-1]};
              end
              OP_MOV: begin data_next = op2;  en_write_next = 1'b1; end
              OP_NOT: begin data_next = ~op1; en_write_next = 1'b1; end
              // Zero-length shift or rotate: pass op1 through, flags untouched.
              OP_SAR, OP_SLR, OP_SAL, OP_SLL, OP_ROL, OP_ROR: begin
                data_next     = op1;
                en_write_next = 1'b1;
              end
              OP_JE:  jump_next = zf;
              OP_JB:  jump_next = cf;
              OP_JA:  jump_next = !zf && !cf;
              OP_JL:  jump_next = (sf != of);
              OP_JG:  jump_next = (sf == of) && !zf;
              OP_JMP: jump_next = 1'b1;
              OP_LI:   begin data_next = immdata;    en_write_next = 1'b1; end
              OP_LM:   begin data_next = memorydata; en_write_next = 1'b1; end
              OP_LDIP: begin data_next = dipsdata;   en_write_next = 1'b1; end
              OP_STOREDM:   begin dm_next = op1; en_writedm_next = 1'b1; end
              OP_SHOWRSEG:  begin seg_next = op1; seg_show_next = 1'b1; end
              OP_SHOWDM:    data_next = memorydata;
              OP_SHOWDMSEG: begin seg_next = memorydata; seg_show_next = 1'b1; end
              default: ;
            endcase
          end
        end
      end
      S_SHIFT: begin
        acc_next = step_acc;
        cnt_next = cnt_reg - CNT_ONE;
        if (cnt_reg == CNT_ONE) begin
          data_next     = step_acc;
          en_write_next = 1'b1;
          flags_next    = {step_acc == '0, step_bit, step_acc[WIDTH-1] != msb_reg, step_acc[WIDTH-1]};
          state_next    = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg        <= '0;
      cnt_reg        <= '0;
      op_reg         <= '0;
      msb_reg        <= 1'b0;
      data_reg       <= '0;
      dm_reg         <= '0;
      seg_reg        <= '0;
      flags_reg      <= '0;
      en_write_reg   <= 1'b0;
      en_writedm_reg <= 1'b0;
      jump_reg       <= 1'b0;
      seg_show_reg   <= 1'b0;
    end else begin
      acc_reg        <= acc_next;
      cnt_reg        <= cnt_next;
      op_reg         <= op_next;
      msb_reg        <= msb_next;
      data_reg       <= data_next;
      dm_reg         <= dm_next;
      seg_reg        <= seg_next;
      flags_reg      <= flags_next;
      en_write_reg   <= en_write_next;
      en_writedm_reg <= en_writedm_next;
      jump_reg       <= jump_next;
      seg_show_reg   <= seg_show_next;
    end
  end

  assign in_ready     = (state_reg == S_IDLE);
  assign out_valid    = (state_reg == S_DONE);
  assign data_output  = data_reg;
  assign en_write     = en_write_reg;
  assign en_writedm   = en_writedm_reg;
  assign DatainMemory = dm_reg;
  assign datainseg    = {seg_show_reg, seg_reg};
  assign jump         = jump_reg;
  assign flags        = flags_reg;

endmodule

// File: tb/tb_exec_unit_p.sv
// Scoreboard bench for exec_unit_p: randomized instructions against an arithmetic reference model,
// plus a short directed run on a 16-bit instance.
`timescale 1ns/1ps
module tb_exec_unit_p;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic in_valid, in_ready, out_valid, en_write, en_writedm, jump;
  logic [5:0] aluop;
  logic [W-1:0] op1, op2, immdata, memorydata, dipsdata, data_output, DatainMemory;
  logic [W:0] datainseg;
  logic [3:0] flags;

  exec_unit_p #(.WIDTH(8), .SHW(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .aluop(aluop),
    .op1(op1), .op2(op2), .immdata(immdata), .memorydata(memorydata), .dipsdata(dipsdata),
    .out_valid(out_valid), .data_output(data_output), .en_write(en_write),
    .en_writedm(en_writedm), .DatainMemory(DatainMemory), .datainseg(datainseg),
    .jump(jump), .flags(flags)
  );

  logic in_valid16, in_ready16, out_valid16, en_write16, en_writedm16, jump16;
  logic [5:0] aluop16;
  logic [15:0] op1_16, op2_16, data16, dm16;
  logic [16:0] seg16;
  logic [3:0] flags16;

  exec_unit_p #(.WIDTH(16), .SHW(4)) u16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .aluop(aluop16),
    .op1(op1_16), .op2(op2_16), .immdata(16'h0000), .memorydata(16'h0000), .dipsdata(16'h0000),
    .out_valid(out_valid16), .data_output(data16), .en_write(en_write16),
    .en_writedm(en_writedm16), .DatainMemory(dm16), .datainseg(seg16),
    .jump(jump16), .flags(flags16)
  );

  typedef struct {
    logic [5:0]   op;
    logic [W-1:0] data, dm, segv;
    logic         ew, ewdm, show, jmp, chk;
    logic [3:0]   fl;
    int           lat, acc_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int compared = 0, mismatched = 0, cyc = 0;
  logic [3:0] flags_m;
  logic [W-1:0] data_m;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: flags live in flags_m as {ZF, CF, OF, SF}.
  function automatic exp_t model(input logic [5:0] op, input logic [W-1:0] a, b, im, mem, dip);
    exp_t e;
    logic [W-1:0] bb, r;
    logic [2*W-1:0] t;
    logic signed [2*W-1:0] ts;
    int n, s, sa, sb;
    logic c;
    e = '{default: 0};
    e.op = op; e.data = data_m; e.fl = flags_m; e.lat = 1;
    sa = int'($signed(a));
    case (op)
      6'd1, 6'd14: begin
        bb = (op == 6'd14) ? 8'd1 : b;
        sb = int'($signed(bb));
        s = int'(a) + int'(bb);
        r = W'(s);
        e.data = r; e.ew = 1; e.chk = 1;
        e.fl = {r == 0, s > 255, (sa + sb > 127) || (sa + sb < -128), r[W-1]};
      end
      6'd3, 6'd15, 6'd18: begin
        bb = (op == 6'd15) ? 8'd1 : b;
        sb = int'($signed(bb));
        r = a - bb;
        if (op != 6'd18) begin e.data = r; e.ew = 1; e.chk = 1; end
        e.fl = {r == 0, a < bb, (sa - sb > 127) || (sa - sb < -128), r[W-1]};
      end
      6'd2, 6'd4, 6'd5: begin
        r = (op == 6'd2) ? (a & b) : (op == 6'd4) ? (a | b) : (a ^ b);
        e.data = r; e.ew = 1; e.chk = 1; e.fl = {r == 0, 2'b00, r[W-1]};
      end
      6'd6: begin e.data = b;  e.ew = 1; e.chk = 1; end
      6'd7: begin e.data = ~a; e.ew = 1; e.chk = 1; end
      6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13: begin
        n = (op >= 6'd12) ? (int'(b) % W) : ((int'(b) > W) ? W : int'(b));
        r = a; c = 1'b0;
        if (n > 0) begin
          case (op)
            6'd8:  begin ts = {a, 8'h00}; ts = ts >>> n; r = ts[2*W-1:W]; c = ts[W-1]; end
            6'd9:  begin t = {a, 8'h00} >> n; r = t[2*W-1:W]; c = t[W-1]; end
            6'd12: begin t = {a, a} << n; r = t[2*W-1:W]; c = r[0]; end
            6'd13: begin t = {a, a} >> n; r = t[W-1:0]; c = r[W-1]; end
            default: begin t = {8'h00, a} << n; r = t[W-1:0]; c = t[W]; end
          endcase
          e.fl = {r == 0, c, r[W-1] != a[W-1], r[W-1]};
          e.lat = 1 + n;
        end
        e.data = r; e.ew = 1; e.chk = 1;
      end
      6'd17: begin e.show = 1; e.segv = a; end
      6'd19: e.jmp = flags_m[3];
      6'd20: e.jmp = flags_m[2];
      6'd21: e.jmp = !flags_m[3] && !flags_m[2];
      6'd22: e.jmp = flags_m[0] != flags_m[1];
      6'd23: e.jmp = (flags_m[0] == flags_m[1]) && !flags_m[3];
      6'd24: e.jmp = 1;
      6'd25: begin e.data = im;  e.ew = 1; e.chk = 1; end
      6'd26: begin e.data = mem; e.ew = 1; e.chk = 1; end
      6'd27: begin e.dm = a; e.ewdm = 1; end
      6'd28: begin e.data = dip; e.ew = 1; e.chk = 1; end
      6'd29: begin e.data = mem; e.chk = 1; end
      6'd30: begin e.show = 1; e.segv = mem; end
      default: ;
    endcase
    flags_m = e.fl;
    data_m = e.data;
    return e;
  endfunction

  // Monitor: pops one expectation per out_valid pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out_valid", 32'(out_valid), 32'(0));
        end else begin
          mon_e = sb_q.pop_front();
          $display("txn op=%0d data=%0h flags=%b ew=%b ewdm=%b jump=%b seg=%0h",
                   mon_e.op, data_output, flags, en_write, en_writedm, jump, datainseg);
          check("latency", 32'(cyc - mon_e.acc_cyc), 32'(mon_e.lat - 1));
          check("flags", 32'(flags), 32'(mon_e.fl));
          check("en_write", 32'(en_write), 32'(mon_e.ew));
          check("en_writedm", 32'(en_writedm), 32'(mon_e.ewdm));
          check("jump", 32'(jump), 32'(mon_e.jmp));
          check("seg_show", 32'(datainseg[W]), 32'(mon_e.show));
          if (mon_e.chk)  check("data_output", 32'(data_output), 32'(mon_e.data));
          if (mon_e.ewdm) check("DatainMemory", 32'(DatainMemory), 32'(mon_e.dm));
          if (mon_e.show) check("seg_value", 32'(datainseg[W-1:0]), 32'(mon_e.segv));
        end
      end else begin
        check("strobes_idle", 32'({en_write, en_writedm, jump, datainseg[W]}), 32'(0));
      end
    end
  end

  task automatic scramble();
    aluop = 6'($urandom); op1 = 8'($urandom); op2 = 8'($urandom);
    immdata = 8'($urandom); memorydata = 8'($urandom); dipsdata = 8'($urandom);
  endtask

  task automatic issue(input logic [5:0] op, input logic [W-1:0] a, b, im, mem, dip);
    exp_t e;
    int guard;
    @(negedge clk);
    aluop = op; op1 = a; op2 = b; immdata = im; memorydata = mem; dipsdata = dip;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 100) begin @(negedge clk); guard++; end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'(1));
      in_valid = 1'b0;
      return;
    end
    e = model(op, a, b, im, mem, dip);
    e.acc_cyc = cyc + 1;
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((sb_q.size() != 0 || !in_ready) && guard < 300) begin @(negedge clk); guard++; end
    if (sb_q.size() != 0) check("drain_timeout", 32'(sb_q.size()), 32'(0));
  endtask

  task automatic issue16(input logic [5:0] op, input logic [15:0] a, b);
    int guard;
    @(negedge clk);
    aluop16 = op; op1_16 = a; op2_16 = b; in_valid16 = 1'b1;
    guard = 0;
    while (!in_ready16 && guard < 100) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    in_valid16 = 1'b0; op1_16 = 16'($urandom); op2_16 = 16'($urandom);
    guard = 0;
    @(negedge clk);
    while (!out_valid16 && guard < 40) begin @(negedge clk); guard++; end
    if (!out_valid16) check("w16_out_valid_timeout", 32'(out_valid16), 32'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] op;
    logic [W-1:0] b;
    rst = 1'b1; in_valid = 1'b0; in_valid16 = 1'b0;
    aluop = '0; op1 = '0; op2 = '0; immdata = '0; memorydata = '0; dipsdata = '0;
    aluop16 = '0; op1_16 = '0; op2_16 = '0;
    flags_m = '0; data_m = '0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_data", 32'(data_output), 32'(0));
    check("rst_flags", 32'(flags), 32'(0));
    check("rst_strobes", 32'({en_write, en_writedm, jump, datainseg}), 32'(0));
    repeat (3) @(negedge clk);
    rst = 1'b0;

    issue(6'd1, 8'h7F, 8'h01, 8'h00, 8'h00, 8'h00);
    wait_idle();
    check("tp_add_data", 32'(data_output), 32'(8'h80));
    check("tp_add_flags", 32'(flags), 32'(4'b0011));

    issue(6'd3, 8'h05, 8'h05, 8'h00, 8'h00, 8'h00);
    issue(6'd19, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    wait_idle();
    check("tp_sub_je_flags", 32'(flags), 32'(4'b1000));

    issue(6'd8, 8'h81, 8'd3, 8'h00, 8'h00, 8'h00);
    wait_idle();
    check("tp_sar_data", 32'(data_output), 32'(8'hF0));
    check("tp_sar_cf", 32'(flags[2]), 32'(0));

    issue(6'd12, 8'h81, 8'd9, 8'h00, 8'h00, 8'h00);
    wait_idle();
    check("tp_rol_data", 32'(data_output), 32'(8'h03));
    check("tp_rol_cf", 32'(flags[2]), 32'(1));

    issue(6'd11, 8'hA5, 8'd7, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midshift_in_ready", 32'(in_ready), 32'(1));
    check("midshift_flags", 32'(flags), 32'(0));
    check("midshift_out_valid", 32'(out_valid), 32'(0));
    sb_q.delete();
    flags_m = '0; data_m = '0;
    @(negedge clk);
    rst = 1'b0;
    issue(6'd1, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00);
    wait_idle();
    check("post_rst_add", 32'(data_output), 32'(8'h46));

    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 99) < 90) ? 6'($urandom_range(0, 30)) : 6'($urandom_range(31, 63));
      b = 8'($urandom);
      if (op >= 6'd8 && op <= 6'd13 && $urandom_range(0, 3) != 0) b = 8'($urandom_range(0, 10));
      issue(op, 8'($urandom), b, 8'($urandom), 8'($urandom), 8'($urandom));
    end
    wait_idle();

    issue16(6'd1, 16'hFFFF, 16'h0001);
    check("w16_add_data", 32'(data16), 32'(16'h0000));
    check("w16_add_flags", 32'(flags16), 32'(4'b1100));
    check("w16_add_strobes", 32'({en_write16, en_writedm16, jump16, seg16[16]}), 32'(4'b1000));
    issue16(6'd27, 16'h1234, 16'h0000);
    check("w16_store_en", 32'({en_write16, en_writedm16}), 32'(2'b01));
    check("w16_store_data", 32'(dm16), 32'(16'h1234));
    issue16(6'd17, 16'h1234, 16'h0000);
    check("w16_showrseg", 32'(seg16), 32'(17'h11234));
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
